// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported backing memory between instruction fetch
// (IF) and load/store (D). One transaction is in flight at a time. D has
// fixed priority, and a starvation counter forces an IF grant after
// STARVE_LIMIT consecutive lost fetch arbitrations.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  // Fetch port
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ready_o,
  // Data port
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_ready_o,
  // Pipeline hold terms
  output logic                stall_if_o,
  output logic                stall_mem_o,
  // Backing memory
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_rvalid_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam bit               BOOST_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_D
  } state_e;

  state_e              state_q,      state_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                if_ready_q,   if_ready_d;
  logic                d_ready_q,    d_ready_d;
  logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,    d_rdata_d;
  logic                mem_req_q,    mem_req_d;
  logic                mem_we_q,     mem_we_d;
  logic [BE_W-1:0]     mem_be_q,     mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;

  logic if_elig, d_elig, boost, grant_if, grant_d;

  // A requester whose completion pulse is high this cycle is not re-granted.
  assign if_elig = if_req_i & ~if_ready_q;
  assign d_elig  = d_req_i  & ~d_ready_q;
  assign boost   = BOOST_EN && (starve_cnt_q == CNT_MAX);

  // Next-state, grant decision, command capture and completion handling.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned; a missing default would infer a latch.
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    grant_if     = 1'b0;
    grant_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_if = if_elig & (~d_elig | boost);
        grant_d  = d_elig & ~grant_if;
        if (grant_if) begin
          state_d      = WAIT_IF;
          starve_cnt_d = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_be_d     = {BE_W{1'b1}};
          mem_addr_d   = if_addr_i;
          mem_wdata_d  = '0;
        end else if (grant_d) begin
          state_d     = WAIT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_be_d    = d_be_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          // Fetch lost a contested arbitration.
          if (if_elig && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_IF: begin
        if (mem_rvalid_i) begin
          state_d    = IDLE;
          if_ready_d = 1'b1;
          if_rdata_d = mem_rdata_i;
        end
      end
      WAIT_D: begin
        if (mem_rvalid_i) begin
          state_d   = IDLE;
          d_ready_d = 1'b1;
          // The issued command is still held, so mem_we_q names the op.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset drops any transaction.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_ready_o  = if_ready_q;
  assign d_ready_o   = d_ready_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stall_if_o  = if_req_i & ~if_ready_q;
  assign stall_mem_o = d_req_i & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, a bench-side
// latency-programmable memory responder, and a transaction-level reference
// model compared against the DUT every cycle.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, stall_if, stall_mem;
  logic        mem_req, mem_we, mem_rvalid;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE)) dut (
    .clock_i(clk), .reset_i(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ready_o(d_ready),
    .stall_if_o(stall_if), .stall_mem_o(stall_mem),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] mem_arr [logic [31:0]];
  int          lat = 1;
  int          remaining = 0;
  logic [31:0] r_addr;
  logic        r_we;
  bit          stray = 1'b0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : (a ^ 32'hA5A5_0000);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      remaining = 0;
    end else if (mem_req) begin
      remaining = lat;
      r_addr    = mem_addr;
      r_we      = mem_we;
      if (mem_we) begin
        logic [31:0] w;
        w = rd(mem_addr);
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
        mem_arr[mem_addr] = w;
      end
    end
    #2;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hBAD0_BAD0;
    if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = r_we ? 32'h0 : rd(r_addr);
      end
    end
    if (stray) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5A5A_5A5A;
    end
  end

  // ---------------- reference model ----------------
  // Transaction view: either nothing is outstanding, or exactly one op
  // (fetch, load or store) waits for its memory completion.
  bit          started = 1'b0;
  bit          m_busy = 1'b0, m_for_if = 1'b0, m_load = 1'b0, m_fresh = 1'b1;
  int          m_starve = 0;
  bit          want_if, want_d, give_if;
  logic        e_if_ready = 1'b0, e_d_ready = 1'b0, e_mem_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_if_rdata = '0, e_d_rdata = '0, e_addr = '0, e_wdata = '0;
  logic [3:0]  e_be = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      started = 1'b1;
      m_busy = 0; m_fresh = 1; m_starve = 0;
      e_if_ready = 0; e_d_ready = 0; e_mem_req = 0;
      e_if_rdata = '0; e_d_rdata = '0;
    end else begin
      want_if = if_req && !e_if_ready;
      want_d  = d_req && !e_d_ready;
      e_if_ready = 0; e_d_ready = 0; e_mem_req = 0;
      if (m_busy) begin
        if (mem_rvalid) begin
          m_busy = 0;
          if (m_for_if) begin
            e_if_ready = 1; e_if_rdata = mem_rdata;
          end else begin
            e_d_ready = 1;
            if (m_load) e_d_rdata = mem_rdata;
          end
        end
      end else if (want_if || want_d) begin
        give_if = want_if && (!want_d || (STARVE > 0 && m_starve >= STARVE));
        m_busy = 1; m_fresh = 0; e_mem_req = 1;
        m_for_if = give_if;
        if (give_if) begin
          m_starve = 0;
          e_we = 0; e_be = 4'hF; e_addr = if_addr;
        end else begin
          if (want_if) m_starve = (m_starve + 1 > STARVE) ? STARVE : m_starve + 1;
          m_load = !d_we;
          e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
        end
      end
    end
  end

  // ---------------- per-cycle comparison + issue log ----------------
  bit   grants[$];
  int   req_cnt = 0;
  int   last_req_cyc = 0;

  always @(negedge clk) begin
    if (started) begin
      check("if_ready",  {63'd0, if_ready},  {63'd0, e_if_ready});
      check("d_ready",   {63'd0, d_ready},   {63'd0, e_d_ready});
      check("mem_req",   {63'd0, mem_req},   {63'd0, e_mem_req});
      check("stall_if",  {63'd0, stall_if},  {63'd0, if_req & ~e_if_ready});
      check("stall_mem", {63'd0, stall_mem}, {63'd0, d_req & ~e_d_ready});
      check("if_rdata",  {32'd0, if_rdata},  {32'd0, e_if_rdata});
      check("d_rdata",   {32'd0, d_rdata},   {32'd0, e_d_rdata});
      if (m_busy) begin
        check("mem_we",   {63'd0, mem_we},   {63'd0, e_we});
        check("mem_be",   {60'd0, mem_be},   {60'd0, e_be});
        check("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
        if (!m_for_if) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_wdata});
      end else if (m_fresh) begin
        check("rst_cmd", {mem_we, mem_be, mem_addr, 27'd0},
              {1'b0, 4'h0, 32'h0, 27'd0});
      end
      if (mem_req && !reset) begin
        grants.push_back(mem_addr == 32'h800);
        req_cnt++;
        last_req_cyc = cyc;
      end
    end
  end

  task automatic wait_ready(input bit for_if, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((for_if && if_ready) || (!for_if && d_ready)) return;
    end
    check(for_if ? "if_ready timeout" : "d_ready timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int  t0, c0, gbase;
    bit  if_done, done;
    bit  exp_seq [6];
    exp_seq = '{0, 0, 0, 0, 1, 0};

    mem_arr[32'h0000_0400] = 32'h2402_000A;
    mem_arr[32'h0000_0404] = 32'h0000_0013;
    mem_arr[32'h1001_0000] = 32'hDEAD_BEEF;
    mem_arr[32'h0000_0800] = 32'h0000_0800;
    reset = 1; if_req = 0; d_req = 0; d_we = 0; d_be = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (3) tick();
    check("reset outs", {if_ready, d_ready, mem_req, if_rdata, d_rdata},
          {3'b000, 32'h0, 32'h0});
    reset = 0;
    tick();

    // Fetch only, L=1.
    lat = 1; if_req = 1; if_addr = 32'h400; t0 = cyc;
    wait_ready(1, 20);
    check("fetch latency",  64'(cyc - t0), 64'd3);
    check("fetch issue",    64'(last_req_cyc - t0), 64'd1);
    check("fetch rdata",    {32'd0, if_rdata}, 64'h2402_000A);
    if_req = 0;
    tick();

    // Simultaneous fetch + load: D first, IF granted in the d_ready cycle.
    if_req = 1; if_addr = 32'h404; d_req = 1; d_we = 0; d_addr = 32'h1001_0000;
    wait_ready(0, 20);
    check("load rdata", {32'd0, d_rdata}, 64'hDEAD_BEEF);
    d_req = 0;
    tick();
    check("if after d", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h404});
    wait_ready(1, 20);
    check("if rdata 2", {32'd0, if_rdata}, 64'h0000_0013);
    if_req = 0;
    tick();

    // Store, L=3: d_ready at T+5, d_rdata untouched.
    lat = 3; d_req = 1; d_we = 1; d_be = 4'b0011;
    d_addr = 32'h1001_0004; d_wdata = 32'h1234_ABCD; t0 = cyc;
    tick();
    check("store cmd", {mem_req, mem_we, mem_be, mem_wdata}, {1'b1, 1'b1, 4'b0011, 32'h1234_ABCD});
    wait_ready(0, 20);
    check("store latency", 64'(cyc - t0), 64'd5);
    check("store keeps d_rdata", {32'd0, d_rdata}, 64'hDEAD_BEEF);
    d_req = 0; d_we = 0; d_be = 0;
    tick();

    // Starvation: D wins 4 contested rounds, then IF, then D again.
    lat = 1; gbase = grants.size(); if_done = 0; done = 0;
    if_req = 1; if_addr = 32'h800; d_req = 1; d_addr = 32'h1001_0000;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (if_ready) if_done = 1;
      if (d_ready && grants.size() - gbase >= 6) begin
        d_req = 0; done = 1;
      end
      if_req = !if_done && !d_ready;
    end
    if (!done) check("starve timeout", 64'd0, 64'd1);
    for (int k = 0; k < 6; k++)
      check($sformatf("grant[%0d] is_if", k),
            {63'd0, (grants.size() > gbase + k) ? grants[gbase + k] : 1'bx},
            {63'd0, exp_seq[k]});
    if_req = 0;
    tick();

    // Reset in WAIT_D, stray rvalid two cycles after release.
    lat = 3; d_req = 1; d_we = 0; d_addr = 32'h1001_0000;
    tick();
    tick();
    reset = 1; d_req = 0;
    tick();
    tick();
    reset = 0;
    tick();
    tick();
    stray = 1;
    tick();
    stray = 0;
    repeat (3) begin
      tick();
      check("post-reset outs", {if_ready, d_ready, mem_req, mem_we, mem_be, mem_addr, if_rdata, d_rdata},
            {8'h00, 32'h0, 32'h0, 32'h0});
    end

    // L=5 fetch, d_req rises mid-wait: D issued the cycle after if_ready.
    lat = 5; if_req = 1; if_addr = 32'h404; t0 = cyc; c0 = req_cnt;
    tick();
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h1001_0000;
    wait_ready(1, 30);
    check("l5 latency", 64'(cyc - t0), 64'd7);
    check("l5 single issue", 64'(req_cnt - c0), 64'd1);
    if_req = 0;
    tick();
    check("d issued after if", {mem_req, mem_addr}, {1'b1, 32'h1001_0000});
    wait_ready(0, 30);
    check("l5 load rdata", {32'd0, d_rdata}, 64'hDEAD_BEEF);
    d_req = 0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Allows at most one outstanding transaction. Data access has fixed priority over fetch.
- A starvation counter guarantees fetch progress.
- The stall outputs feed the pipeline hold logic alongside the existing ID/EX stall terms.

Parameters:
- ADDR_W, 32, width of address buses.
- DATA_W, 32, width of data buses (byte-enable width is DATA_W/8).
- STARVE_LIMIT, 4, number of consecutive lost fetch arbitrations before fetch is forced to win. 0 disables the boost.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held with if_addr stable until if_ready.
- if_addr  input  ADDR_W  fetch address.
- if_rdata  output  DATA_W  fetched word; valid while if_ready=1, held afterwards.
- if_ready  output  1  one-cycle completion pulse for fetch.
- d_req  input  1  data request; held stable with d_we/d_be/d_addr/d_wdata until d_ready.
- d_we  input  1  1=store, 0=load.
- d_be  input  DATA_W/8  byte enables for stores.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_rdata  output  DATA_W  load result; updated only on load completion.
- d_ready  output  1  one-cycle completion pulse for data.
- stall_if  output  1  combinational: if_req & ~if_ready.
- stall_mem  output  1  combinational: d_req & ~d_ready.
- mem_req  output  1  one-cycle issue pulse to backing memory.
- mem_we, mem_be, mem_addr, mem_wdata  output  1/DATA_W/8/ADDR_W/DATA_W  issued command; registered, stable from the issue cycle until mem_rvalid.
- mem_rdata  input  DATA_W  memory read data, valid with mem_rvalid.
- mem_rvalid  input  1  completion from memory; read data or write acknowledge. Earliest possible is the cycle after mem_req.

Behaviour:
- States: IDLE, WAIT_IF, WAIT_D.
- Eligibility in IDLE:
  - IF is eligible when if_req & ~if_ready.
  - D is eligible when d_req & ~d_ready.
  - A requester whose ready pulse is high this cycle is therefore not re-granted.
- Grant in IDLE:
  - Both eligible: grant IF if starve_cnt == STARVE_LIMIT and STARVE_LIMIT != 0; otherwise grant D.
  - Only one eligible: grant it.
  - None eligible: stay in IDLE.
- On grant: next state is WAIT_IF or WAIT_D. mem_req=1 and the mem_* command are registered, so they appear in the first WAIT cycle only. mem_we=0 and mem_be=all-ones for fetch.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) when both are eligible and D wins.
  - It clears on any IF grant.
  - It is unchanged otherwise.
- In WAIT_x:
  - mem_req=0 after the first cycle.
  - mem_rvalid=0: remain in WAIT_x.
  - mem_rvalid=1: next cycle x_ready=1. if_rdata takes mem_rdata; d_rdata takes mem_rdata only if the op was a load. State returns to IDLE.
- Timing: request eligible at cycle T → mem_req at T+1 → mem_rvalid at T+1+L (L≥1) → x_ready at T+2+L. Minimum 3-cycle turnaround.
- mem_rvalid in IDLE (spurious or after reset) is ignored.
- Only one ready pulse can be high per cycle.
- Reset values: state IDLE, starve_cnt 0, if_ready 0, d_ready 0, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, if_rdata 0, d_rdata 0.
- Reset mid-WAIT drops the outstanding transaction; no ready pulse is produced for it.
- Requests changing while not yet granted are legal. Requests changing while in WAIT are a protocol violation; the behaviour is undefined.

Test Plan:
- Fetch only, if_addr=0x400, memory answers L=1 with 0x2402000A → mem_req at T+1, mem_rvalid at T+2, if_ready pulse at T+3 with if_rdata=0x2402000A, stall_if high T..T+2.
- Simultaneous if_req and d_req load 0x10010000 (data 0xDEADBEEF) → D served first, d_rdata=0xDEADBEEF. IF is granted in the IDLE cycle of d_ready, since d_req is then ineligible.
- Store d_addr=0x10010004, d_be=4'b0011, d_wdata=0x1234ABCD, L=3 → mem_we=1, mem_be=0011, mem_wdata=0x1234ABCD; d_ready at T+5; d_rdata unchanged.
- d_req held continuously with if_req, STARVE_LIMIT=4 → D wins 4 arbitrations, 5th goes to IF, starve_cnt returns to 0, D wins the following one.
- reset asserted in WAIT_D, stray mem_rvalid 2 cycles after reset release → no d_ready, all outputs 0, state IDLE.
- L=5 fetch with d_req rising mid-wait → no second mem_req until fetch completes; D issued the cycle after if_ready.
